dec_lut_decoder30bits_clk: RTL and testbench
============================================

Name: dec_lut_decoder30bits_clk

Overview:
- Sequential, LUT-based Fibonacci-weight decoder.
- Converts a 46-bit codeword W into an unsigned integer N, where N = sum of F(i+2) over every set bit W[i], with F(1)=F(2)=1.
- A ROM LUT of Fibonacci weights is walked one bit per clock; `found` flags that N is valid.
- Sits downstream of the encoded-word path and delivers integers of up to 31 bits to consumers.
- Canonical (Zeckendorf) and non-canonical codewords are both accepted, so several W values may decode to the same N.

Parameters:
- W_BITS, 46, codeword width; the LUT has W_BITS entries.
- N_BITS, 31, output width; results saturate to 2^N_BITS-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- W  input  W_BITS  codeword; held stable by the producer until `found`.
- found  output  1  high when N is the decode of the currently latched W.
- N  output  N_BITS  decoded integer.

Behaviour:
- Single clock domain (clk); reset (rst) is synchronous, active-high.
- LUT: entry i = F(i+2), 33-bit constants (1, 2, 3, 5, 8, ...; entry 45 = F(47) = 2971215073). Implemented as a combinational case ROM.
- Registers:
  - w_q (W_BITS): latched codeword.
  - acc (33 bits): running sum.
  - idx (6 bits): bit index.
  - state: LOAD, RUN, DONE.
  - N, found.
- Reset (rst high at posedge): state=LOAD, acc=0, idx=0, w_q=0, N=0, found=0.
- Load condition: state==LOAD, or W != w_q in any state.
- On a load cycle: w_q<=W, acc<=0, idx<=0, found<=0, state<=RUN. N holds its old value but is invalid while found=0.
- RUN, no load condition:
  - acc <= acc + (w_q[idx] ? LUT[idx] : 0), saturating at 2^33-1 (cannot be reached with 46 bits, but guard anyway).
  - idx <= idx+1.
  - When idx == W_BITS-1: N <= (new acc > 2^N_BITS-1) ? 2^N_BITS-1 : new acc[N_BITS-1:0]; found<=1; state<=DONE.
- DONE: N and found hold until the next load condition or reset.
- Latency: W changes before posedge k → latched at k → bits 0..45 processed at k+1..k+46. found=1 and N valid after posedge k+46, i.e. 47 edges.
- A W change mid-RUN aborts and restarts on that edge; found stays 0. No partial result is ever presented with found=1.
- W toggling every cycle keeps found=0 indefinitely.
- Reset mid-operation wins over everything, then the block re-decodes the current W from LOAD.
- found is a level, not a pulse. No start or ack signal; a change of W is the request.
- Only positions 0..45 are decoded; there are no unused W bits.

Test Plan:
- Reset with rst=1 for 2 cycles, W=0 → found=0 and N=0 during reset; found=1 and N=0 47 edges after rst falls.
- W=1 → N=1; W=2 → N=2; W=4 → N=3; W=3 (non-canonical, F2+F3) → N=3. found rises exactly 47 edges after each W change.
- W = Zeckendorf encoding of 1073741823 from the bench reference model, plus two non-canonical variants built with F(i)+F(i+1)=F(i+2) rewrites → N=1073741823 for all three.
- W = all ones (sum F2..F47 = 7778742047) → N=2147483647 (saturated); W = bit 45 only (2971215073) → N=2147483647; W = bit 44 only (F46 = 1836311903) → N=1836311903.
- Change W from 1 to 2 at 20 cycles into a decode → found stays 0, then rises 47 edges after the change with N=2. No found pulse with N=1 may appear.
- Assert rst for 1 cycle mid-decode of W=4 → found=0 and N=0 next edge, then N=3 with found=1 after 47 further edges. Holding W=4 in DONE keeps found=1 and N=3 stable for 100 cycles.

Source files
------------

// File: rtl/dec_lut_decoder30bits_clk_if.sv
// Codeword/result bundle between a Fibonacci-codeword producer and the decoder.
//   W     : codeword, held stable by the producer until found
//   found : level, high while N is the decode of the latched W
//   N     : decoded integer, saturated to N_BITS
interface dec_lut_decoder30bits_clk_if #(
    parameter int unsigned W_BITS = 46,
    parameter int unsigned N_BITS = 31
);
    logic [W_BITS-1:0] W;
    logic              found;
    logic [N_BITS-1:0] N;

    // Producer side: drives the codeword, consumes the result.
    modport master (
        output W,
        input  found,
        input  N
    );

    // Decoder side.
    modport slave (
        input  W,
        output found,
        output N
    );
endinterface

// File: rtl/dec_lut_decoder30bits_clk.sv
// Sequential LUT-based Fibonacci-weight decoder.
// Walks the latched codeword one bit per clock, adding F(i+2) for every set
// bit i, and presents the saturated sum on N with found held high.
// Any change of W (or leaving reset) restarts the decode; found never shows
// a partial result.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of dec_lut_decoder30bits_clk_if (W in, found/N out)
module dec_lut_decoder30bits_clk #(
    parameter int unsigned W_BITS = 46,
    parameter int unsigned N_BITS = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    dec_lut_decoder30bits_clk_if.slave    bus
);

    localparam int unsigned ACC_BITS = 33;
    localparam int unsigned IDX_BITS = 6;
    localparam logic [ACC_BITS-1:0] N_MAX =
        {{(ACC_BITS-N_BITS){1'b0}}, {N_BITS{1'b1}}};
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(W_BITS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    // Weight ROM: entry i is F(i+2) with F(1)=F(2)=1.
    function automatic logic [ACC_BITS-1:0] fib_weight(input logic [IDX_BITS-1:0] i);
        logic [ACC_BITS-1:0] v;
        case (i)
            6'd0:    v = 33'd1;
            6'd1:    v = 33'd2;
            6'd2:    v = 33'd3;
            6'd3:    v = 33'd5;
            6'd4:    v = 33'd8;
            6'd5:    v = 33'd13;
            6'd6:    v = 33'd21;
            6'd7:    v = 33'd34;
            6'd8:    v = 33'd55;
            6'd9:    v = 33'd89;
            6'd10:   v = 33'd144;
            6'd11:   v = 33'd233;
            6'd12:   v = 33'd377;
            6'd13:   v = 33'd610;
            6'd14:   v = 33'd987;
            6'd15:   v = 33'd1597;
            6'd16:   v = 33'd2584;
            6'd17:   v = 33'd4181;
            6'd18:   v = 33'd6765;
            6'd19:   v = 33'd10946;
            6'd20:   v = 33'd17711;
            6'd21:   v = 33'd28657;
            6'd22:   v = 33'd46368;
            6'd23:   v = 33'd75025;
            6'd24:   v = 33'd121393;
            6'd25:   v = 33'd196418;
            6'd26:   v = 33'd317811;
            6'd27:   v = 33'd514229;
            6'd28:   v = 33'd832040;
            6'd29:   v = 33'd1346269;
            6'd30:   v = 33'd2178309;
            6'd31:   v = 33'd3524578;
            6'd32:   v = 33'd5702887;
            6'd33:   v = 33'd9227465;
            6'd34:   v = 33'd14930352;
            6'd35:   v = 33'd24157817;
            6'd36:   v = 33'd39088169;
            6'd37:   v = 33'd63245986;
            6'd38:   v = 33'd102334155;
            6'd39:   v = 33'd165580141;
            6'd40:   v = 33'd267914296;
            6'd41:   v = 33'd433494437;
            6'd42:   v = 33'd701408733;
            6'd43:   v = 33'd1134903170;
            6'd44:   v = 33'd1836311903;
            6'd45:   v = 33'd2971215073;
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t              state;
    logic [W_BITS-1:0]   w_q;
    logic [ACC_BITS-1:0] acc;
    logic [IDX_BITS-1:0] idx;
    logic [N_BITS-1:0]   n_q;
    logic                found_q;

    logic                load_c;
    logic [ACC_BITS-1:0] addend_c;
    logic [ACC_BITS:0]   sum_c;
    logic [ACC_BITS-1:0] acc_next_c;
    logic [N_BITS-1:0]   n_sat_c;

    // Restart request, weight of the current bit and saturated running sum.
    always_comb begin
        load_c     = (state == S_LOAD) || (bus.W != w_q);
        addend_c   = w_q[idx] ? fib_weight(idx) : '0;
        sum_c      = {1'b0, acc} + {1'b0, addend_c};
        acc_next_c = sum_c[ACC_BITS] ? '1 : sum_c[ACC_BITS-1:0];
        n_sat_c    = (acc_next_c > N_MAX) ? N_MAX[N_BITS-1:0]
                                          : acc_next_c[N_BITS-1:0];
    end

    // Decode FSM; a load outranks RUN/DONE so a changed W always restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            w_q     <= '0;
            acc     <= '0;
            idx     <= '0;
            n_q     <= '0;
            found_q <= 1'b0;
        end else if (load_c) begin
            state   <= S_RUN;
            w_q     <= bus.W;
            acc     <= '0;
            idx     <= '0;
            found_q <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    acc <= acc_next_c;
                    idx <= idx + IDX_BITS'(1);
                    if (idx == IDX_LAST) begin
                        n_q     <= n_sat_c;
                        found_q <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.N     = n_q;
    assign bus.found = found_q;

endmodule

// File: tb/tb_dec_lut_decoder30bits_clk.sv
// Self-checking bench for dec_lut_decoder30bits_clk against an arithmetic
// Fibonacci-sum reference.
module tb_dec_lut_decoder30bits_clk;

    localparam int unsigned W_BITS  = 46;
    localparam int unsigned N_BITS  = 31;
    localparam int          LATENCY = 47;
    localparam longint      N_MAX   = 64'd2147483647;

    logic clk;
    logic rst;

    dec_lut_decoder30bits_clk_if #(.W_BITS(W_BITS), .N_BITS(N_BITS)) bus ();

    dec_lut_decoder30bits_clk #(.W_BITS(W_BITS), .N_BITS(N_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     vectors;
    int     miscompares;
    longint fib [0:50];

    // Fibonacci table F(0..50), F(1)=F(2)=1.
    function automatic void build_fib();
        fib[0] = 0;
        fib[1] = 1;
        for (int k = 2; k <= 50; k++) fib[k] = fib[k-1] + fib[k-2];
    endfunction

    // Reference: sum of F(i+2) over set bits, saturated to N_BITS.
    function automatic logic [N_BITS-1:0] ref_decode(input logic [W_BITS-1:0] w);
        longint s = 0;
        for (int i = 0; i < W_BITS; i++) if (w[i]) s += fib[i+2];
        if (s > N_MAX) s = N_MAX;
        return N_BITS'(s);
    endfunction

    // Greedy Zeckendorf encoding.
    function automatic logic [W_BITS-1:0] zeck(input longint v);
        logic [W_BITS-1:0] w = '0;
        longint rem = v;
        for (int i = W_BITS - 1; i >= 0; i--) begin
            if (fib[i+2] <= rem) begin
                w[i] = 1'b1;
                rem -= fib[i+2];
            end
        end
        return w;
    endfunction

    // One F(i+2) = F(i+1) + F(i) rewrite on the highest eligible set bit.
    function automatic logic [W_BITS-1:0] rewrite(input logic [W_BITS-1:0] w);
        logic [W_BITS-1:0] r = w;
        for (int i = W_BITS - 1; i >= 2; i--) begin
            if (r[i] && !r[i-1] && !r[i-2]) begin
                r[i]   = 1'b0;
                r[i-1] = 1'b1;
                r[i-2] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    // Drive a new codeword and count edges until found rises (-1 if never).
    task automatic measure(input logic [W_BITS-1:0] w, output int rise,
                           output logic [N_BITS-1:0] n);
        @(negedge clk);
        bus.W = w;
        rise  = -1;
        n     = '0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus.found === 1'b1) begin
                rise = e;
                n    = bus.N;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int rise;
        @(negedge clk);
        rst   = 1'b1;
        bus.W = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.found !== 1'b0 || bus.N !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: found=%b N=%0d, required found=0 N=0", bus.found, bus.N);
            end
        end
        @(negedge clk);
        rst  = 1'b0;
        rise = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus.found === 1'b1) begin
                rise = e;
                break;
            end
        end
        vectors++;
        if (rise != LATENCY || bus.N !== '0) begin
            miscompares++;
            $display("FAIL reset_release: rise=%0d N=%0d, required rise=%0d N=0", rise, bus.N, LATENCY);
        end
    endtask

    task automatic test_small();
        logic [W_BITS-1:0] ws [4];
        int                rise;
        logic [N_BITS-1:0] n;
        ws[0] = 46'd1; ws[1] = 46'd2; ws[2] = 46'd4; ws[3] = 46'd3;
        for (int k = 0; k < 4; k++) begin
            measure(ws[k], rise, n);
            vectors++;
            if (rise != LATENCY || n !== ref_decode(ws[k])) begin
                miscompares++;
                $display("FAIL small W=%0d: rise=%0d N=%0d, required rise=%0d N=%0d",
                         ws[k], rise, n, LATENCY, ref_decode(ws[k]));
            end
        end
    endtask

    task automatic test_zeckendorf();
        logic [W_BITS-1:0] ws [3];
        int                rise;
        logic [N_BITS-1:0] n;
        ws[0] = zeck(64'd1073741823);
        ws[1] = rewrite(ws[0]);
        ws[2] = rewrite(ws[1]);
        for (int k = 0; k < 3; k++) begin
            measure(ws[k], rise, n);
            vectors++;
            if (rise != LATENCY || n !== 31'd1073741823) begin
                miscompares++;
                $display("FAIL zeck variant %0d W=%h: rise=%0d N=%0d, required rise=%0d N=1073741823",
                         k, ws[k], rise, n, LATENCY);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W_BITS-1:0] ws  [3];
        logic [N_BITS-1:0] exp [3];
        int                rise;
        logic [N_BITS-1:0] n;
        ws[0] = '1;                      exp[0] = 31'd2147483647;
        ws[1] = 46'd1 << 45;             exp[1] = 31'd2147483647;
        ws[2] = 46'd1 << 44;             exp[2] = 31'd1836311903;
        for (int k = 0; k < 3; k++) begin
            measure(ws[k], rise, n);
            vectors++;
            if (rise != LATENCY || n !== exp[k] || n !== ref_decode(ws[k])) begin
                miscompares++;
                $display("FAIL saturation W=%h: rise=%0d N=%0d, required rise=%0d N=%0d",
                         ws[k], rise, n, LATENCY, exp[k]);
            end
        end
    endtask

    task automatic test_abort();
        int                rise;
        logic [N_BITS-1:0] n;
        int                early;
        @(negedge clk);
        bus.W = 46'd1;
        early = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.found !== 1'b0) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL abort_pre: found high on %0d cycles, required 0", early);
        end
        measure(46'd2, rise, n);
        vectors++;
        if (rise != LATENCY || n !== 31'd2) begin
            miscompares++;
            $display("FAIL abort_restart: rise=%0d N=%0d, required rise=%0d N=2", rise, n, LATENCY);
        end
    endtask

    task automatic test_toggle();
        int                bad;
        int                rise;
        logic [N_BITS-1:0] n;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.W = (c % 2 == 0) ? 46'd5 : 46'd6;
            @(posedge clk);
            #1;
            if (bus.found !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL toggle: found high on %0d cycles, required 0", bad);
        end
        measure(46'd9, rise, n);
        vectors++;
        if (rise != LATENCY || n !== ref_decode(46'd9)) begin
            miscompares++;
            $display("FAIL toggle_settle: rise=%0d N=%0d, required rise=%0d N=%0d",
                     rise, n, LATENCY, ref_decode(46'd9));
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        int bad;
        @(negedge clk);
        bus.W = 46'd4;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.found !== 1'b0 || bus.N !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: found=%b N=%0d, required found=0 N=0", bus.found, bus.N);
        end
        @(negedge clk);
        rst  = 1'b0;
        rise = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus.found === 1'b1) begin
                rise = e;
                break;
            end
        end
        vectors++;
        if (rise != LATENCY || bus.N !== 31'd3) begin
            miscompares++;
            $display("FAIL reset_mid_redecode: rise=%0d N=%0d, required rise=%0d N=3", rise, bus.N, LATENCY);
        end
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.found !== 1'b1 || bus.N !== 31'd3) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL done_hold: %0d unstable cycles, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [W_BITS-1:0] w;
        logic [W_BITS-1:0] prev;
        int                rise;
        logic [N_BITS-1:0] n;
        prev = bus.W;
        for (int k = 0; k < 10; k++) begin
            w = {14'($urandom), 32'($urandom)};
            w = w >> $urandom_range(0, 40);
            if (w == prev) w = w ^ 46'd1;
            prev = w;
            measure(w, rise, n);
            vectors++;
            if (rise != LATENCY || n !== ref_decode(w)) begin
                miscompares++;
                $display("FAIL random W=%h: rise=%0d N=%0d, required rise=%0d N=%0d",
                         w, rise, n, LATENCY, ref_decode(w));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.W       = '0;
        build_fib();
        test_reset();
        test_small();
        test_zeckendorf();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
